// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bit positions shared by the ALU and its decoder
package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_SHL = 4'h4, OP_SHR = 4'h5, OP_XOR = 4'h6, OP_ASR = 4'h7,
    OP_ADC = 4'h8, OP_SBC = 4'h9, OP_MUL = 4'hA, OP_CMP = 4'hB
  } op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
endpackage

// File: rtl/alu_seq_mul_iter.sv
// alu_mul_iter: WIDTH-step right-shifting shift-add unsigned multiplier; prod is valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  // acc holds {partial high half, unconsumed multiplier bits}; prod is the next step's value
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
  assign prod = {sum, acc[WIDTH-1:1]};
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_q  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= {{WIDTH{1'b0}}, b};
      a_q  <= a;
    end else if (busy) begin
      acc  <= prod;
      cnt  <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, persistent NZCV flags and iterative MUL
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   in_sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_err,
  output logic [3:0]       flags
);
  state_e state, nxt;
  logic accept, is_mul, ld_alu, mul_busy, mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] sum, shl, shr, sar;
  logic [WIDTH-1:0] bx, fr, r;
  logic sub_t, cin, c, v, err;
  assign in_ready  = state == ST_IDLE || (state == ST_DONE && out_ready);
  assign out_valid = state == ST_DONE;
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && in_op == OP_MUL;
  assign ld_alu    = accept && !is_mul;
  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .rst_n(rst_n), .start(accept && is_mul), .a(in_a), .b(in_b),
        .busy(mul_busy), .done(mul_done), .prod(prod)
      );
    end else begin : g_nomul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign prod     = '0;
    end
  endgenerate
  always_comb begin
    nxt = state == ST_BUSY ? (mul_done ? ST_DONE : mul_busy ? ST_BUSY : ST_IDLE)
        : accept ? (is_mul ? ST_BUSY : ST_DONE)
        : (state == ST_DONE && !out_ready) ? ST_DONE : ST_IDLE;
  end
  // Subtraction is A + ~B + cin, so the add overflow rule on (A, bx) covers every arithmetic op
  always_comb begin
    sub_t = in_op == OP_SUB || in_op == OP_CMP || in_op == OP_SBC;
    bx    = sub_t ? ~in_b : in_b;
    cin   = (in_op == OP_SUB || in_op == OP_CMP) ? 1'b1
          : in_op == OP_ADC ? flags[FLG_C]
          : in_op == OP_SBC ? ~flags[FLG_C] : 1'b0;
    sum   = {1'b0, in_a} + {1'b0, bx} + (WIDTH+1)'(cin);
    shl   = {1'b0, in_a} << in_sh;
    shr   = {in_a, 1'b0} >> in_sh;
    sar   = $unsigned($signed({in_a, 1'b0}) >>> in_sh);
    fr    = '0;
    c     = 1'b0;
    v     = 1'b0;
    err   = 1'b0;
    case (in_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
        fr = sum[WIDTH-1:0];
        c  = sum[WIDTH] ^ sub_t;
        v  = (in_a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND: fr = in_a & in_b;
      OP_OR:  fr = in_a | in_b;
      OP_XOR: fr = in_a ^ in_b;
      OP_SHL: {c, fr} = shl;
      OP_SHR: {fr, c} = shr;
      OP_ASR: {fr, c} = sar;
      default: err = 1'b1;
    endcase
    r = in_op == OP_CMP ? in_a : fr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_result <= '0;
      out_hi     <= '0;
      out_err    <= 1'b0;
      flags      <= '0;
    end else begin
      state <= nxt;
      if (ld_alu) begin
        out_result <= r;
        out_hi     <= '0;
        out_err    <= err;
        if (!err) flags <= {fr[WIDTH-1], ~|fr, c, v};
      end else if (mul_done) begin
        out_result <= prod[WIDTH-1:0];
        out_hi     <= prod[2*WIDTH-1:WIDTH];
        out_err    <= 1'b0;
        flags      <= {prod[WIDTH-1], ~|prod[WIDTH-1:0], |prod[2*WIDTH-1:WIDTH], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, handshake/reset corner sequences and random ops against an integer model
module tb_alu_seq;
  localparam int W  = 8;
  localparam int SW = 3;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_op = '0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [SW-1:0] in_sh = '0;
  logic in_ready, out_valid, out_err;
  logic [W-1:0] out_result, out_hi;
  logic [3:0] flags;
  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_sh(in_sh), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_hi(out_hi), .out_err(out_err), .flags(flags)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] op; logic [W-1:0] a, b; logic [SW-1:0] sh;
    logic [W-1:0] r, hi; logic err; logic [3:0] f;
  } vec_t;
  typedef struct { logic [W-1:0] r, hi; logic err; logic [3:0] f; int lat; } res_t;
  int n_checks = 0, n_fail = 0;
  logic [3:0] mflags;
  vec_t vt[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Reference behaviour from plain signed/unsigned integer arithmetic
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [SW-1:0] sh, input logic [3:0] fin);
    res_t e;
    int ua, ub, sa, sb, c, n, full, ss;
    logic [W-1:0] fv;
    logic cf, vf;
    ua = int'(a); ub = int'(b); sa = $signed(a); sb = $signed(b);
    c = int'(fin[1]); n = int'(sh);
    e.hi = '0; e.err = 1'b0; e.lat = 1; fv = '0; cf = 1'b0; vf = 1'b0; full = 0; ss = 0;
    case (op)
      4'h0, 4'h8: begin
        full = ua + ub + (op == 4'h8 ? c : 0);
        ss   = sa + sb + (op == 4'h8 ? c : 0);
        cf   = full >= (1 << W);
      end
      4'h1, 4'h9, 4'hB: begin
        full = ua - ub - (op == 4'h9 ? c : 0);
        ss   = sa - sb - (op == 4'h9 ? c : 0);
        cf   = full < 0;
      end
      4'h2: fv = a & b;
      4'h3: fv = a | b;
      4'h6: fv = a ^ b;
      4'h4: begin full = ua << n; cf = n == 0 ? 1'b0 : full[W]; end
      4'h5: begin full = ua >> n; cf = n == 0 ? 1'b0 : ((ua >> (n - 1)) & 1) != 0; end
      4'h7: begin full = sa >>> n; cf = n == 0 ? 1'b0 : ((sa >>> (n - 1)) & 1) != 0; end
      4'hA: begin full = ua * ub; e.hi = W'(full >> W); cf = e.hi != 0; e.lat = W + 1; end
      default: e.err = 1'b1;
    endcase
    if (op inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB}) fv = W'(full);
    if (op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hB}) vf = ss > (1 << (W - 1)) - 1 || ss < -(1 << (W - 1));
    e.r = op == 4'hB ? a : fv;
    e.f = e.err ? fin : {fv[W-1], fv == 0, cf, vf};
    return e;
  endfunction
  // Called on a falling edge; returns on the falling edge where out_valid is first seen
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] sh, output res_t o);
    out_ready = 1'b1; in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_sh = sh;
    #1 check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_sh = SW'($urandom);
    o.lat = 0;
    do begin
      @(negedge clk);
      o.lat++;
      if (!out_valid) check("busy_ready_low", 32'(in_ready), 32'd0);
    end while (!out_valid && o.lat < 40);
    o.r = out_result; o.hi = out_hi; o.err = out_err; o.f = flags;
  endtask
  task automatic compare(input string tag, input res_t o, input res_t e);
    check({tag, "_result"}, 32'(o.r), 32'(e.r));
    check({tag, "_hi"}, 32'(o.hi), 32'(e.hi));
    check({tag, "_err"}, 32'(o.err), 32'(e.err));
    check({tag, "_flags"}, 32'(o.f), 32'(e.f));
    check({tag, "_latency"}, 32'(o.lat), 32'(e.lat));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    res_t o, e;
    int stall;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [SW-1:0] sh;
    vt.push_back('{4'h0, 8'h7F, 8'h01, 3'd0, 8'h80, 8'h00, 1'b0, 4'b1001});
    vt.push_back('{4'h0, 8'hFF, 8'h01, 3'd0, 8'h00, 8'h00, 1'b0, 4'b0110});
    vt.push_back('{4'h8, 8'h00, 8'h00, 3'd0, 8'h01, 8'h00, 1'b0, 4'b0000});
    vt.push_back('{4'h1, 8'h05, 8'h07, 3'd0, 8'hFE, 8'h00, 1'b0, 4'b1010});
    vt.push_back('{4'hB, 8'h07, 8'h07, 3'd0, 8'h07, 8'h00, 1'b0, 4'b0100});
    vt.push_back('{4'h4, 8'h81, 8'h00, 3'd1, 8'h02, 8'h00, 1'b0, 4'b0010});
    vt.push_back('{4'h7, 8'h80, 8'h00, 3'd3, 8'hF0, 8'h00, 1'b0, 4'b1000});
    vt.push_back('{4'h5, 8'h03, 8'h00, 3'd0, 8'h03, 8'h00, 1'b0, 4'b0000});
    vt.push_back('{4'hA, 8'hFF, 8'hFF, 3'd0, 8'h01, 8'hFE, 1'b0, 4'b0010});
    vt.push_back('{4'hD, 8'h12, 8'h34, 3'd0, 8'h00, 8'h00, 1'b1, 4'b0010});
    vt.push_back('{4'h0, 8'h80, 8'h80, 3'd0, 8'h00, 8'h00, 1'b0, 4'b0111});
    vt.push_back('{4'h9, 8'h10, 8'h01, 3'd0, 8'h0E, 8'h00, 1'b0, 4'b0000});
    vt.push_back('{4'h1, 8'h00, 8'h01, 3'd0, 8'hFF, 8'h00, 1'b0, 4'b1010});
    vt.push_back('{4'h9, 8'h05, 8'h02, 3'd0, 8'h02, 8'h00, 1'b0, 4'b0000});
    vt.push_back('{4'h6, 8'hF0, 8'hFF, 3'd0, 8'h0F, 8'h00, 1'b0, 4'b0000});
    vt.push_back('{4'h2, 8'hF0, 8'h3C, 3'd0, 8'h30, 8'h00, 1'b0, 4'b0000});
    vt.push_back('{4'h3, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 4'b0100});
    vt.push_back('{4'h4, 8'h03, 8'h00, 3'd7, 8'h80, 8'h00, 1'b0, 4'b1010});
    vt.push_back('{4'h5, 8'h80, 8'h00, 3'd7, 8'h01, 8'h00, 1'b0, 4'b0000});
    vt.push_back('{4'h7, 8'h81, 8'h00, 3'd1, 8'hC0, 8'h00, 1'b0, 4'b1010});
    vt.push_back('{4'hF, 8'hAA, 8'h55, 3'd2, 8'h00, 8'h00, 1'b1, 4'b1010});
    vt.push_back('{4'hA, 8'h00, 8'h37, 3'd0, 8'h00, 8'h00, 1'b0, 4'b0100});
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_hi", 32'(out_hi), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, o);
      e = '{vt[i].r, vt[i].hi, vt[i].err, vt[i].f, vt[i].op == 4'hA ? W + 1 : 1};
      compare($sformatf("vec%0d", i), o, e);
    end
    // Back-to-back accepts with in_valid held: one result per cycle, in_ready stays high
    in_valid = 1'b1; in_op = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      in_a = W'(k); in_b = W'(k);
      @(negedge clk);
      check("b2b_result", 32'(out_result), 32'(2 * k));
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    // MUL result held while the consumer stalls
    run_op(4'hA, 8'hFF, 8'hFF, 3'd0, o);
    check("mul_lat", 32'(o.lat), 32'(W + 1));
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(out_result), 32'h01);
      check("hold_hi", 32'(out_hi), 32'hFE);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);
    // Asynchronous reset in the middle of a MUL
    run_op(4'h1, 8'h00, 8'h01, 3'd0, o);
    in_valid = 1'b1; in_op = 4'hA; in_a = 8'hFF; in_b = 8'hFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_result", 32'(out_result), 32'd0);
    check("arst_hi", 32'(out_hi), 32'd0);
    check("arst_err", 32'(out_err), 32'd0);
    check("arst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'h0, 8'h03, 8'h04, 3'd0, o);
    compare("post_rst", o, '{8'h07, 8'h00, 1'b0, 4'b0000, 1});
    mflags = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom); sh = SW'($urandom);
      e = model(op, a, b, sh, mflags);
      run_op(op, a, b, sh, o);
      compare($sformatf("rnd%0d_op%0h", i, op), o, e);
      mflags = e.f;
      stall = $urandom_range(0, 2);
      out_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check("rnd_stall_valid", 32'(out_valid), 32'd1);
        check("rnd_stall_result", 32'(out_result), 32'(e.r));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
